// File: rtl/axi_chk_pkg.sv
// Shared constants for the AXI write-channel checker: error bit map,
// burst encodings, channel indices and the stability-snapshot state.
package axi_chk_pkg;
  localparam int ERR_AW_STABLE   = 0;
  localparam int ERR_W_STABLE    = 1;
  localparam int ERR_B_STABLE    = 2;
  localparam int ERR_WLAST_EARLY = 3;
  localparam int ERR_WLAST_MISS  = 4;
  localparam int ERR_W_NO_AW     = 5;
  localparam int ERR_B_NO_BURST  = 6;
  localparam int ERR_OVERFLOW    = 7;
  localparam int ERR_NUM         = 8;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam int CH_AW  = 0;
  localparam int CH_W   = 1;
  localparam int CH_B   = 2;
  localparam int CH_NUM = 3;

  typedef enum logic {
    SNAP_IDLE  = 1'b0,
    SNAP_STALL = 1'b1
  } snap_st_e;
endpackage

// File: rtl/axi_chk_len_fifo.sv
// Small synchronous FIFO holding outstanding AW burst lengths.
// Pointers carry a wrap bit; push while full is accepted only with a pop.
module axi_chk_len_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [PW:0]      count
);
  logic [PW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                 (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign count = wr_ptr_q - rd_ptr_q;
  assign dout  = mem_q[rd_ptr_q[PW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    // At full the write lands in the slot being vacated by the pop.
    if (push && (!full || pop)) begin
      mem_d[wr_ptr_q[PW-1:0]] = din;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop && !empty) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) mem_q <= mem_d;
endmodule

// File: rtl/axi_wr_checker.sv
// Passive AXI write-channel protocol checker: handshake stability,
// burst length tracking, response pairing and saturating statistics.
module axi_wr_checker
  import axi_chk_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 64,
  parameter int MAX_OUT = 4,
  parameter int CNTW    = 16,
  localparam int OW     = $clog2(MAX_OUT) + 1
) (
  input  logic            axi_aclk,
  input  logic            rst,
  input  logic [AW-1:0]   axi_awaddr,
  input  logic [7:0]      axi_awlen,
  input  logic [2:0]      axi_awsize,
  input  logic [1:0]      axi_awburst,
  input  logic            axi_awvalid,
  input  logic            axi_awready,
  input  logic [DW-1:0]   axi_wdata,
  input  logic [DW/8-1:0] axi_wstrb,
  input  logic            axi_wlast,
  input  logic            axi_wvalid,
  input  logic            axi_wready,
  input  logic [1:0]      axi_bresp,
  input  logic            axi_bvalid,
  input  logic            axi_bready,
  output logic [7:0]      err_flags,
  output logic            err_pulse,
  output logic [3:0]      first_err_code,
  output logic [CNTW-1:0] aw_count,
  output logic [CNTW-1:0] w_beat_count,
  output logic [CNTW-1:0] b_count,
  output logic [OW-1:0]   outstanding
);
  localparam int AWP = AW + 13;
  localparam int WP  = DW + DW/8 + 1;

  logic [CH_NUM-1:0] vld, rdy, chg, stab_err;
  logic aw_hs, w_hs, b_hs;
  logic [AWP-1:0] aw_pl, aw_snap_q, aw_snap_d;
  logic [WP-1:0]  w_pl, w_snap_q, w_snap_d;
  logic [1:0]     b_snap_q, b_snap_d;
  snap_st_e       st_q [CH_NUM];
  snap_st_e       st_d [CH_NUM];

  assign vld   = {axi_bvalid, axi_wvalid, axi_awvalid};
  assign rdy   = {axi_bready, axi_wready, axi_awready};
  assign aw_hs = axi_awvalid & axi_awready;
  assign w_hs  = axi_wvalid & axi_wready;
  assign b_hs  = axi_bvalid & axi_bready;
  assign aw_pl = {axi_awaddr, axi_awlen, axi_awsize, axi_awburst};
  assign w_pl  = {axi_wdata, axi_wstrb, axi_wlast};
  assign chg   = {axi_bresp != b_snap_q, w_pl != w_snap_q, aw_pl != aw_snap_q};

  always_ff @(posedge axi_aclk) begin
    for (int i = 0; i < CH_NUM; i++) st_q[i] <= rst ? SNAP_IDLE : st_d[i];
  end

  always_comb begin
    for (int i = 0; i < CH_NUM; i++) begin
      st_d[i] = st_q[i];
      case (st_q[i])
        SNAP_IDLE:  if (vld[i] && !rdy[i]) st_d[i] = SNAP_STALL;
        SNAP_STALL: if (!vld[i] || rdy[i]) st_d[i] = SNAP_IDLE;
        default:    st_d[i] = SNAP_IDLE;
      endcase
    end
  end

  // Snapshot is taken only on entry to STALL and held while stalled.
  always_comb begin
    aw_snap_d = aw_snap_q;
    w_snap_d  = w_snap_q;
    b_snap_d  = b_snap_q;
    for (int i = 0; i < CH_NUM; i++)
      stab_err[i] = (st_q[i] == SNAP_STALL) && (!vld[i] || chg[i]);
    if (st_q[CH_AW] == SNAP_IDLE && vld[CH_AW] && !rdy[CH_AW]) aw_snap_d = aw_pl;
    if (st_q[CH_W]  == SNAP_IDLE && vld[CH_W]  && !rdy[CH_W])  w_snap_d  = w_pl;
    if (st_q[CH_B]  == SNAP_IDLE && vld[CH_B]  && !rdy[CH_B])  b_snap_d  = axi_bresp;
  end

  logic [7:0]    beat_q, beat_d, head_len;
  logic [OW-1:0] pend_q, pend_d;
  logic          q_full, q_empty, q_push, q_pop, w_ok, pend_inc, pend_dec, pend_max;

  axi_chk_len_fifo #(.DEPTH(MAX_OUT), .WIDTH(8)) u_len_fifo (
    .clk  (axi_aclk),
    .rst  (rst),
    .push (q_push),
    .pop  (q_pop),
    .din  (axi_awlen),
    .dout (head_len),
    .full (q_full),
    .empty(q_empty),
    .count(outstanding)
  );

  assign w_ok     = w_hs && !q_empty;
  assign q_pop    = w_ok && ((beat_q == head_len) || (axi_wlast && beat_q < head_len));
  assign q_push   = aw_hs && (!q_full || q_pop);
  assign pend_inc = q_pop;
  assign pend_dec = b_hs && (pend_q != '0);
  assign pend_max = (pend_q == OW'(MAX_OUT));

  logic [7:0]      err_vec, err_flags_q, err_flags_d;
  logic            err_pulse_q, err_pulse_d;
  logic [3:0]      code_q, code_d;
  logic [CNTW-1:0] aw_cnt_q, aw_cnt_d, w_cnt_q, w_cnt_d, b_cnt_q, b_cnt_d;

  always_comb begin
    err_vec                  = '0;
    err_vec[ERR_AW_STABLE]   = stab_err[CH_AW];
    err_vec[ERR_W_STABLE]    = stab_err[CH_W];
    err_vec[ERR_B_STABLE]    = stab_err[CH_B];
    err_vec[ERR_WLAST_EARLY] = w_ok && axi_wlast && (beat_q < head_len);
    err_vec[ERR_WLAST_MISS]  = w_ok && !axi_wlast && (beat_q == head_len);
    err_vec[ERR_W_NO_AW]     = w_hs && q_empty;
    err_vec[ERR_B_NO_BURST]  = b_hs && (pend_q == '0);
    err_vec[ERR_OVERFLOW]    = (aw_hs && q_full && !q_pop) ||
                               (pend_inc && pend_max && !pend_dec);

    beat_d = beat_q;
    if (w_ok) beat_d = q_pop ? 8'd0 : beat_q + 8'd1;

    pend_d = pend_q;
    if (pend_inc && !pend_dec && !pend_max) pend_d = pend_q + 1'b1;
    else if (!pend_inc && pend_dec)         pend_d = pend_q - 1'b1;

    err_flags_d = err_flags_q | err_vec;
    err_pulse_d = |(err_vec & ~err_flags_q);
    code_d      = code_q;
    if (code_q == 4'd0)
      for (int i = ERR_NUM - 1; i >= 0; i--) if (err_vec[i]) code_d = 4'(i + 1);

    aw_cnt_d = aw_cnt_q + CNTW'(aw_hs && (aw_cnt_q != '1));
    w_cnt_d  = w_cnt_q  + CNTW'(w_hs  && (w_cnt_q  != '1));
    b_cnt_d  = b_cnt_q  + CNTW'(b_hs  && (b_cnt_q  != '1));
  end

  always_ff @(posedge axi_aclk) begin
    if (rst) begin
      aw_snap_q   <= '0;
      w_snap_q    <= '0;
      b_snap_q    <= '0;
      beat_q      <= '0;
      pend_q      <= '0;
      err_flags_q <= '0;
      err_pulse_q <= 1'b0;
      code_q      <= '0;
      aw_cnt_q    <= '0;
      w_cnt_q     <= '0;
      b_cnt_q     <= '0;
    end else begin
      aw_snap_q   <= aw_snap_d;
      w_snap_q    <= w_snap_d;
      b_snap_q    <= b_snap_d;
      beat_q      <= beat_d;
      pend_q      <= pend_d;
      err_flags_q <= err_flags_d;
      err_pulse_q <= err_pulse_d;
      code_q      <= code_d;
      aw_cnt_q    <= aw_cnt_d;
      w_cnt_q     <= w_cnt_d;
      b_cnt_q     <= b_cnt_d;
    end
  end

  assign err_flags      = err_flags_q;
  assign err_pulse      = err_pulse_q;
  assign first_err_code = code_q;
  assign aw_count       = aw_cnt_q;
  assign w_beat_count   = w_cnt_q;
  assign b_count        = b_cnt_q;
endmodule

// File: tb/tb_axi_wr_checker.sv
// Bench for axi_wr_checker: directed scenarios plus randomized traffic,
// every cycle compared against a queue-based reference model.
module tb_axi_wr_checker;
  localparam int AW = 32, DW = 64, MAX_OUT = 4, CNTW = 16, OW = $clog2(MAX_OUT) + 1;

  logic            axi_aclk = 1'b0;
  logic            rst = 1'b1;
  logic [AW-1:0]   axi_awaddr = '0;
  logic [7:0]      axi_awlen = '0;
  logic [2:0]      axi_awsize = '0;
  logic [1:0]      axi_awburst = '0;
  logic            axi_awvalid = 1'b0, axi_awready = 1'b0;
  logic [DW-1:0]   axi_wdata = '0;
  logic [DW/8-1:0] axi_wstrb = '0;
  logic            axi_wlast = 1'b0, axi_wvalid = 1'b0, axi_wready = 1'b0;
  logic [1:0]      axi_bresp = '0;
  logic            axi_bvalid = 1'b0, axi_bready = 1'b0;
  logic [7:0]      err_flags;
  logic            err_pulse;
  logic [3:0]      first_err_code;
  logic [CNTW-1:0] aw_count, w_beat_count, b_count;
  logic [OW-1:0]   outstanding;

  axi_wr_checker #(.AW(AW), .DW(DW), .MAX_OUT(MAX_OUT), .CNTW(CNTW)) dut (
    .axi_aclk(axi_aclk), .rst(rst),
    .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
    .axi_awburst(axi_awburst), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .err_flags(err_flags), .err_pulse(err_pulse), .first_err_code(first_err_code),
    .aw_count(aw_count), .w_beat_count(w_beat_count), .b_count(b_count),
    .outstanding(outstanding)
  );

  always #5 axi_aclk = ~axi_aclk;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the length queue as a SV queue, plain integers elsewhere.
  int        m_q[$];
  int        m_beat, m_pend, m_aw, m_w, m_b, m_first;
  bit [7:0]  m_flags;
  bit        m_pulse;
  bit        p_aw_st, p_w_st, p_b_st;
  bit [44:0] p_aw;
  bit [72:0] p_w;
  bit [1:0]  p_b;

  task automatic model_step();
    bit [7:0] e;
    bit aw_hs, w_hs, b_hs, done, dec;
    int occ;
    if (rst) begin
      m_q.delete();
      m_beat = 0; m_pend = 0; m_aw = 0; m_w = 0; m_b = 0; m_first = 0;
      m_flags = 0; m_pulse = 0; p_aw_st = 0; p_w_st = 0; p_b_st = 0;
      return;
    end
    e = 0; done = 0;
    aw_hs = axi_awvalid && axi_awready;
    w_hs  = axi_wvalid && axi_wready;
    b_hs  = axi_bvalid && axi_bready;
    if (p_aw_st && (!axi_awvalid || p_aw != {axi_awaddr, axi_awlen, axi_awsize, axi_awburst})) e[0] = 1;
    if (p_w_st && (!axi_wvalid || p_w != {axi_wdata, axi_wstrb, axi_wlast})) e[1] = 1;
    if (p_b_st && (!axi_bvalid || p_b != axi_bresp)) e[2] = 1;
    occ = m_q.size();
    if (w_hs) begin
      if (occ == 0) e[5] = 1;
      else begin
        if (axi_wlast && m_beat < m_q[0]) e[3] = 1;
        if (!axi_wlast && m_beat == m_q[0]) e[4] = 1;
        if (axi_wlast || m_beat == m_q[0]) done = 1;
        else m_beat++;
      end
    end
    if (done) begin void'(m_q.pop_front()); m_beat = 0; end
    if (aw_hs) begin
      if (occ == MAX_OUT && !done) e[7] = 1;
      else m_q.push_back(int'(axi_awlen));
    end
    dec = b_hs && m_pend > 0;
    if (b_hs && m_pend == 0) e[6] = 1;
    if (done && m_pend == MAX_OUT && !dec) e[7] = 1;
    else if (done) m_pend++;
    if (dec) m_pend--;
    if (aw_hs && m_aw < 65535) m_aw++;
    if (w_hs && m_w < 65535) m_w++;
    if (b_hs && m_b < 65535) m_b++;
    m_pulse = |(e & ~m_flags);
    if (m_first == 0)
      for (int i = 7; i >= 0; i--) if (e[i]) m_first = i + 1;
    m_flags |= e;
    p_aw_st = axi_awvalid && !axi_awready;
    p_w_st  = axi_wvalid && !axi_wready;
    p_b_st  = axi_bvalid && !axi_bready;
    p_aw = {axi_awaddr, axi_awlen, axi_awsize, axi_awburst};
    p_w  = {axi_wdata, axi_wstrb, axi_wlast};
    p_b  = axi_bresp;
  endtask

  task automatic cmp_all();
    chk("err_flags", 32'(err_flags), 32'(m_flags));
    chk("err_pulse", 32'(err_pulse), 32'(m_pulse));
    chk("first_err_code", 32'(first_err_code), 32'(m_first));
    chk("aw_count", 32'(aw_count), 32'(m_aw));
    chk("w_beat_count", 32'(w_beat_count), 32'(m_w));
    chk("b_count", 32'(b_count), 32'(m_b));
    chk("outstanding", 32'(outstanding), 32'(m_q.size()));
  endtask

  task automatic tick();
    @(posedge axi_aclk);
    model_step();
    #1;
    cmp_all();
  endtask

  task automatic idle();
    axi_awvalid = 0; axi_awready = 0;
    axi_wvalid = 0; axi_wready = 0; axi_wlast = 0;
    axi_bvalid = 0; axi_bready = 0;
  endtask

  task automatic do_reset();
    idle(); rst = 1; tick(); rst = 0;
  endtask

  task automatic aw_beat(input logic [7:0] len);
    axi_awvalid = 1; axi_awready = 1; axi_awlen = len;
    axi_awaddr = $urandom; axi_awburst = 2'b01; axi_awsize = 3'd3;
  endtask

  task automatic w_beat(input logic last);
    axi_wvalid = 1; axi_wready = 1; axi_wlast = last;
    axi_wdata = {$urandom, $urandom}; axi_wstrb = 8'hff;
  endtask

  task automatic rand_drive();
    if (!(axi_awvalid && !axi_awready) || $urandom_range(99) < 5) begin
      axi_awvalid = 1'($urandom); axi_awaddr = $urandom;
      axi_awlen = 8'($urandom_range(3)); axi_awsize = 3'($urandom); axi_awburst = 2'($urandom);
    end else if ($urandom_range(99) < 3) axi_awaddr = axi_awaddr + 4;
    axi_awready = 1'($urandom);
    if (!(axi_wvalid && !axi_wready) || $urandom_range(99) < 5) begin
      axi_wvalid = 1'($urandom); axi_wdata = {$urandom, $urandom}; axi_wstrb = 8'($urandom);
      if (m_q.size() > 0) axi_wlast = (m_beat == m_q[0]) ^ ($urandom_range(9) == 0);
      else axi_wlast = 1'($urandom);
    end
    axi_wready = 1'($urandom);
    if (!(axi_bvalid && !axi_bready) || $urandom_range(99) < 5) begin
      axi_bvalid = (m_pend > 0) ? 1'($urandom) : ($urandom_range(19) == 0);
      axi_bresp = 2'($urandom);
    end
    axi_bready = 1'($urandom);
  endtask

  initial begin
    idle();
    rst = 1; tick();
    chk("rst_flags", 32'(err_flags), 0);
    chk("rst_code", 32'(first_err_code), 0);
    chk("rst_outstanding", 32'(outstanding), 0);
    rst = 0;

    // Clean burst of 4 beats then response.
    aw_beat(8'd3); tick(); idle();
    for (int b = 0; b < 4; b++) begin w_beat(b == 3); tick(); end
    idle(); axi_bvalid = 1; axi_bready = 1; axi_bresp = 2'b00; tick();
    idle(); tick();
    chk("t1_flags", 32'(err_flags), 0);
    chk("t1_aw", 32'(aw_count), 1);
    chk("t1_w", 32'(w_beat_count), 4);
    chk("t1_b", 32'(b_count), 1);
    chk("t1_out", 32'(outstanding), 0);

    // Early wlast on beat 1.
    do_reset();
    aw_beat(8'd3); tick(); idle();
    w_beat(0); tick(); w_beat(1); tick(); idle();
    chk("t2_flags", 32'(err_flags), 32'h08);
    chk("t2_code", 32'(first_err_code), 4);
    chk("t2_pulse", 32'(err_pulse), 1);
    chk("t2_out", 32'(outstanding), 0);
    tick();
    chk("t2_pulse_drop", 32'(err_pulse), 0);

    // AW payload change while stalled.
    do_reset();
    axi_awvalid = 1; axi_awready = 0; axi_awaddr = 32'h100; axi_awlen = 0; tick();
    axi_awaddr = 32'h104; tick(); idle(); tick();
    chk("t3_flags", 32'(err_flags), 32'h01);
    chk("t3_code", 32'(first_err_code), 1);

    // Queue overflow.
    do_reset();
    for (int i = 0; i < 4; i++) begin aw_beat(8'd0); tick(); end
    chk("t4_flags_full", 32'(err_flags), 0);
    aw_beat(8'd0); tick(); idle();
    chk("t4_flags", 32'(err_flags), 32'h80);
    chk("t4_out", 32'(outstanding), 4);

    // Same-cycle AW and W on empty queue.
    do_reset();
    aw_beat(8'd0); w_beat(1); tick(); idle();
    chk("t5_flags", 32'(err_flags), 32'h20);
    chk("t5_out", 32'(outstanding), 1);
    w_beat(1); tick(); idle();
    chk("t5_out_pop", 32'(outstanding), 0);
    chk("t5_flags_hold", 32'(err_flags), 32'h20);

    // B in the same cycle as the final beat, then reset mid-burst.
    do_reset();
    aw_beat(8'd0); tick(); idle();
    w_beat(1); axi_bvalid = 1; axi_bready = 1; tick(); idle();
    chk("t6_flags", 32'(err_flags), 32'h40);
    chk("t6_code", 32'(first_err_code), 7);
    aw_beat(8'd3); tick(); idle(); w_beat(0); tick();
    idle(); rst = 1; tick(); rst = 0;
    chk("t6_rst_flags", 32'(err_flags), 0);
    chk("t6_rst_code", 32'(first_err_code), 0);
    chk("t6_rst_aw", 32'(aw_count), 0);
    chk("t6_rst_w", 32'(w_beat_count), 0);
    chk("t6_rst_b", 32'(b_count), 0);
    chk("t6_rst_out", 32'(outstanding), 0);

    // Randomized traffic in short segments so sticky flags stay informative.
    for (int s = 0; s < 40; s++) begin
      do_reset();
      for (int c = 0; c < 30; c++) begin rand_drive(); tick(); end
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
